// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared state encoding, result layout and sizing helper for the serial comparator
package comp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'b00;
  localparam state_t COMPARE = 2'b01;
  localparam state_t DONE    = 2'b10;

  // Result bits packed as {eq, gt, lt}; indices usable on that concatenation.
  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } res_t;

  localparam int RES_EQ = 2;
  localparam int RES_GT = 1;
  localparam int RES_LT = 0;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/comp_bit_mag.sv
// rtl/comp_bit_mag.sv - combinational 1-bit magnitude comparison cell
module comp_bit_mag (
  input  logic x,
  input  logic y,
  output logic bit_eq,
  output logic bit_gt,
  output logic bit_lt
);

  assign bit_eq = ~(x ^ y);
  assign bit_gt = x & ~y;
  assign bit_lt = ~x & y;

endmodule

// File: rtl/comp_serial_mag.sv
// rtl/comp_serial_mag.sv - bit-serial MSB-first unsigned magnitude comparator with valid/ready on both sides
module comp_serial_mag
  import comp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  res_t             res_q, res_d;

  logic bit_eq, bit_gt, bit_lt;
  logic load_en, shift_en, cap_en, last_bit;

  comp_bit_mag u_cell (
    .x      (a_sh_q[WIDTH-1]),
    .y      (b_sh_q[WIDTH-1]),
    .bit_eq (bit_eq),
    .bit_gt (bit_gt),
    .bit_lt (bit_lt)
  );

  assign last_bit = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = COMPARE;
      COMPARE: if (!bit_eq || last_bit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;  // 2'b11 is unreachable; fall back to IDLE
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    load_en   = (state_q == IDLE) && in_valid;
    cap_en    = (state_q == COMPARE) && (!bit_eq || last_bit);
    shift_en  = (state_q == COMPARE) && !cap_en;
  end

  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    if (load_en) begin
      a_sh_d = a;
      b_sh_d = b;
      cnt_d  = CNT_INIT;
    end else if (shift_en) begin
      a_sh_d = a_sh_q << 1;
      b_sh_d = b_sh_q << 1;
      cnt_d  = cnt_q - 1'b1;
    end
    if (cap_en) begin
      res_d.eq = bit_eq;
      res_d.gt = bit_gt;
      res_d.lt = bit_lt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
    end
  end

  assign eq = res_q.eq;
  assign gt = res_q.gt;
  assign lt = res_q.lt;

endmodule
